fantasticfft_fftn_framer: RTL and testbench
===========================================

FANTASTICFFT_FFTN_FRAMER -- requirements
Module: fantasticfft_fftn_framer

Interface
REQ-001 The block SHALL have the parameter N_POINTS, default 8: FFT size; power of two, at least 2.
REQ-002 The block SHALL have the parameter INT_SIZE, default 8: integer bits of the fixed-point sample.
REQ-003 The block SHALL have the parameter FRAC_SIZE, default 8: fractional bits; W = INT_SIZE+FRAC_SIZE.
REQ-004 The block SHALL have the parameter TIMEOUT, default 1024: maximum number of WAIT cycles, at least 1.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk, input, 1 bit, sole clock; rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have the port s_valid, input, 1 bit: ingress sample valid.
REQ-007 The block SHALL have the port s_ready, output, 1 bit: ingress ready.
REQ-008 The block SHALL have the port s_data, input, W bits: real input sample.
REQ-009 The block SHALL have the port s_last, input, 1 bit: early end-of-frame marker.
REQ-010 The block SHALL have the port core_x, output, N_POINTS*W bits: frame to the FFT core; point k occupies bits [k*W +: W].
REQ-011 The block SHALL have the port core_isValid, output, 1 bit: one-cycle start pulse to the core.
REQ-012 The block SHALL have the ports core_y and core_y_i, input, N_POINTS*W bits each: core real/imaginary results, same packing as core_x.
REQ-013 The block SHALL have the port core_resultValid, input, 1 bit: core result strobe.
REQ-014 The block SHALL have the ports m_valid (output, 1 bit) and m_ready (input, 1 bit): egress handshake.
REQ-015 The block SHALL have the ports m_re and m_im, output, W bits each: result bin, real/imaginary.
REQ-016 The block SHALL have the ports m_index (output, clog2(N_POINTS) bits, bin number) and m_last (output, 1 bit, high on bin N_POINTS-1).
REQ-017 The block SHALL have the ports frame_err and timeout_err, output, 1 bit each: one-cycle error pulses.

Function
REQ-018 The block SHALL use the states FILL, START, WAIT and DRAIN, and s_ready SHALL equal (state==FILL).
REQ-019 In FILL, each s_valid&&s_ready SHALL write s_data to point wr_idx and increment wr_idx.
REQ-020 When the block accepts point N_POINTS-1, or accepts any point with s_last=1, it SHALL go to START on the next cycle.
REQ-021 If s_last=1 is accepted at wr_idx<N_POINTS-1, the block SHALL zero points wr_idx+1..N_POINTS-1 and pulse frame_err in the cycle after acceptance.
REQ-022 If s_last=0 at point N_POINTS-1, the block SHALL close the frame normally with no error.
REQ-023 In START, the block SHALL hold core_isValid=1 for exactly one cycle and then go to WAIT.
REQ-024 core_x SHALL stay stable from START until the block returns to FILL.
REQ-025 In WAIT, core_resultValid=1 SHALL cause the block to capture core_y/core_y_i into its output registers, go to DRAIN and clear rd_idx.
REQ-026 core_resultValid SHALL be ignored in all states other than WAIT.
REQ-027 If WAIT lasts TIMEOUT cycles without core_resultValid, the block SHALL pulse timeout_err, go to FILL and clear wr_idx.
REQ-028 In DRAIN, m_valid SHALL be 1 and m_re/m_im SHALL present bin rd_idx, with m_index=rd_idx.
REQ-029 m_re, m_im, m_index and m_last SHALL be held while m_valid&&!m_ready.
REQ-030 Each m_valid&&m_ready in DRAIN SHALL increment rd_idx.
REQ-031 A handshake with m_last=1 SHALL send the block to FILL on the next cycle with wr_idx=0.
REQ-032 Minimum latency from the last ingress beat to core_isValid SHALL be 1 cycle, and from core_resultValid to the first m_valid SHALL be 1 cycle.
REQ-033 No arithmetic SHALL be applied to sample data; data widths SHALL pass through unchanged.

Reset
REQ-034 Assertion of rst_n=0 SHALL immediately force state FILL and wr_idx=rd_idx=0, and SHALL clear all storage registers, core_isValid, m_valid, m_last, m_index, m_re, m_im, frame_err, timeout_err and the timeout counter.
REQ-035 Because s_ready=(state==FILL), s_ready SHALL read 1 while the block is in reset and after rst_n deasserts.
REQ-036 Reset mid-frame SHALL discard the partial frame, and reset during DRAIN SHALL drop the remaining bins without emitting m_last.

Structure
REQ-037 The state enum and a W-bit fixed-point sample typedef SHALL be defined in fantasticfft_pkg.
REQ-038 fantasticfft_fftn_framer SHALL be a single module with no sub-module; the FFT core SHALL be instantiated externally.

Verification
REQ-039 With N_POINTS=8, feeding samples 0x0100..0x0800 with no stalls SHALL produce core_x point k = 0x0100*(k+1), a single core_isValid 1 cycle after the 8th beat, and s_ready=0 until the frame has drained.
REQ-040 Sending s_last on the 3rd sample SHALL make points 3..7 equal 0, pulse frame_err once, and then follow the normal START/WAIT sequence.
REQ-041 With a core model returning y=k, y_i=-k after 5 cycles and m_ready tied high, the block SHALL output 8 beats with m_index 0..7 and m_last only on index 7.
REQ-042 Driving m_ready with a random 50% pattern SHALL keep every m_* output stable while stalled, with no beat lost or duplicated.
REQ-043 With TIMEOUT=16 and no core response, the block SHALL pulse timeout_err 16 cycles into WAIT and return s_ready=1 on the next cycle.
REQ-044 Asserting rst_n=0 at the 4th DRAIN beat SHALL immediately clear m_valid, and the next frame after reset SHALL be accepted cleanly from point 0.

Source files
------------

// File: rtl/fantasticfft_pkg.sv
// Shared definitions for the fantasticfft framer: FSM states and the
// default fixed-point sample type (8 integer + 8 fractional bits).
package fantasticfft_pkg;

   localparam int SAMPLE_INT_SIZE  = 8;
   localparam int SAMPLE_FRAC_SIZE = 8;
   localparam int SAMPLE_W         = SAMPLE_INT_SIZE + SAMPLE_FRAC_SIZE;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } framer_state_e;

endpackage

// File: rtl/fantasticfft_fftn_framer.sv
// Collects a frame of real samples for an external FFT core, fires the core,
// then streams the captured complex bins out one per handshake.
module fantasticfft_fftn_framer
   import fantasticfft_pkg::*;
#(
   parameter  int N_POINTS  = 8,
   parameter  int INT_SIZE  = 8,
   parameter  int FRAC_SIZE = 8,
   parameter  int TIMEOUT   = 1024,
   localparam int W         = INT_SIZE + FRAC_SIZE,
   localparam int IDXW      = $clog2(N_POINTS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [W-1:0]          s_data,
   input  logic                  s_last,
   output logic [N_POINTS*W-1:0] core_x,
   output logic                  core_isValid,
   input  logic [N_POINTS*W-1:0] core_y,
   input  logic [N_POINTS*W-1:0] core_y_i,
   input  logic                  core_resultValid,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [W-1:0]          m_re,
   output logic [W-1:0]          m_im,
   output logic [IDXW-1:0]       m_index,
   output logic                  m_last,
   output logic                  frame_err,
   output logic                  timeout_err
);

   localparam int              CNTW     = $clog2(TIMEOUT + 1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_POINTS - 1);
   localparam logic [CNTW-1:0] TO_LAST  = CNTW'(TIMEOUT - 1);

   framer_state_e   state_q, state_d;
   logic [IDXW-1:0] wr_idx_q, wr_idx_d;
   logic [IDXW-1:0] rd_idx_q, rd_idx_d;
   logic [CNTW-1:0] to_cnt_q, to_cnt_d;
   logic            frame_err_q, frame_err_d;
   logic            timeout_err_q, timeout_err_d;
   logic [W-1:0]    frame_q [N_POINTS];
   logic [W-1:0]    re_q    [N_POINTS];
   logic [W-1:0]    im_q    [N_POINTS];

   logic s_fire, m_fire, frame_close, early_last, capture, timed_out;

   assign s_fire      = s_valid && (state_q == FILL);
   assign m_fire      = m_ready && (state_q == DRAIN);
   assign frame_close = s_fire && (s_last || (wr_idx_q == LAST_IDX));
   assign early_last  = s_fire && s_last && (wr_idx_q != LAST_IDX);
   assign capture     = core_resultValid && (state_q == WAIT);
   assign timed_out   = !core_resultValid && (state_q == WAIT) && (to_cnt_q == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (frame_close) state_d = START;
         START:   state_d = WAIT;
         WAIT: begin
            if (capture) begin
               state_d = DRAIN;
            end else if (timed_out) begin
               state_d = FILL;
            end
         end
         DRAIN:   if (m_fire && (rd_idx_q == LAST_IDX)) state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // Egress bins are gated to zero outside DRAIN so nothing stale leaks out.
   always_comb begin
      s_ready      = (state_q == FILL);
      core_isValid = (state_q == START);
      m_valid      = (state_q == DRAIN);
      m_index      = rd_idx_q;
      m_last       = (state_q == DRAIN) && (rd_idx_q == LAST_IDX);
      m_re         = (state_q == DRAIN) ? re_q[rd_idx_q] : '0;
      m_im         = (state_q == DRAIN) ? im_q[rd_idx_q] : '0;
      frame_err    = frame_err_q;
      timeout_err  = timeout_err_q;
   end

   always_comb begin
      wr_idx_d = wr_idx_q;
      if (s_fire) begin
         wr_idx_d = wr_idx_q + 1'b1;
      end
      if ((state_d == FILL) && (state_q != FILL)) begin
         wr_idx_d = '0;
      end

      rd_idx_d = rd_idx_q;
      if (capture) begin
         rd_idx_d = '0;
      end else if (m_fire) begin
         rd_idx_d = rd_idx_q + 1'b1;
      end

      to_cnt_d      = (state_q == WAIT) ? to_cnt_q + 1'b1 : '0;
      frame_err_d   = early_last;
      timeout_err_d = timed_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx_q      <= '0;
         rd_idx_q      <= '0;
         to_cnt_q      <= '0;
         frame_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         wr_idx_q      <= wr_idx_d;
         rd_idx_q      <= rd_idx_d;
         to_cnt_q      <= to_cnt_d;
         frame_err_q   <= frame_err_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // A short frame zero-pads every point above the one carrying s_last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_POINTS; k++) begin
            frame_q[k] <= '0;
            re_q[k]    <= '0;
            im_q[k]    <= '0;
         end
      end else begin
         for (int k = 0; k < N_POINTS; k++) begin
            if (s_fire && (wr_idx_q == IDXW'(k))) begin
               frame_q[k] <= s_data;
            end else if (early_last && (IDXW'(k) > wr_idx_q)) begin
               frame_q[k] <= '0;
            end
            if (capture) begin
               re_q[k] <= core_y[k*W +: W];
               im_q[k] <= core_y_i[k*W +: W];
            end
         end
      end
   end

   always_comb begin
      core_x = '0;
      for (int k = 0; k < N_POINTS; k++) begin
         core_x[k*W +: W] = frame_q[k];
      end
   end

endmodule

// File: tb/tb_fantasticfft_fftn_framer.sv
// Randomized scoreboard bench for the FFT framer: a behavioural frame model and
// an FFT core stand-in feed expected frames/bins into queues checked by a monitor.
module tb_fantasticfft_fftn_framer;
   import fantasticfft_pkg::*;

   localparam int N     = 8;
   localparam int W     = 16;
   localparam int XW    = N * W;
   localparam int IW    = 3;
   localparam int TO    = 16;
   localparam int LIMIT = 600;

   typedef struct packed {
      logic [W-1:0]  re;
      logic [W-1:0]  im;
      logic [IW-1:0] idx;
      logic          last;
   } beat_t;

   logic          clk, rst_n;
   logic          s_valid, s_ready, s_last;
   logic [W-1:0]  s_data;
   logic [XW-1:0] core_x, core_y, core_y_i;
   logic          core_isValid, core_resultValid;
   logic          m_valid, m_ready, m_last;
   logic [W-1:0]  m_re, m_im;
   logic [IW-1:0] m_index;
   logic          frame_err, timeout_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int closeCyc = -1, earlyCyc = -1, lastStartCyc = -1;
   int expFrameErrs = 0, seenFrameErrs = 0, seenTimeouts = 0;
   bit respondEn = 1, fixedDelay = 0, identityData = 0, strayEn = 0, randReady = 0;
   bit frameActive = 0;
   logic [XW-1:0] curFrame;

   logic [XW-1:0] expFrameQ [$];
   beat_t         expBeatQ  [$];

   fantasticfft_fftn_framer #(
      .N_POINTS (N),
      .INT_SIZE (8),
      .FRAC_SIZE(8),
      .TIMEOUT  (TO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .s_data          (s_data),
      .s_last          (s_last),
      .core_x          (core_x),
      .core_isValid    (core_isValid),
      .core_y          (core_y),
      .core_y_i        (core_y_i),
      .core_resultValid(core_resultValid),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .m_re            (m_re),
      .m_im            (m_im),
      .m_index         (m_index),
      .m_last          (m_last),
      .frame_err       (frame_err),
      .timeout_err     (timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [XW-1:0] actual,
                              input logic [XW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic failBound(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
   endtask

   // Sends one frame; earlyAt >= N means no early s_last. Expected frame is
   // zero-initialised so points after an early s_last read back as zero.
   task automatic applyStimulus(input int earlyAt, input bit patterned, input int maxGap);
      logic [XW-1:0] frame;
      sample_t       d;
      bit            last, closing;
      int            waited;
      frame = '0;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         repeat ($urandom_range(0, maxGap)) @(negedge clk);
         d       = patterned ? sample_t'(16'h0100 * (i + 1)) : sample_t'($urandom);
         last    = (i == earlyAt);
         s_valid = 1'b1;
         s_data  = d;
         s_last  = last;
         waited  = 0;
         while (!s_ready && waited < LIMIT) begin
            @(negedge clk);
            waited++;
         end
         if (!s_ready) begin
            failBound("ingress ready");
            s_valid = 1'b0;
            return;
         end
         frame[i*W +: W] = d;
         closing = last || (i == N - 1);
         if (closing) begin
            expFrameQ.push_back(frame);
            closeCyc = cyc + 1;
            if (i < N - 1) begin
               expFrameErrs++;
               earlyCyc = cyc + 1;
            end
         end
         @(negedge clk);
         s_valid = 1'b0;
         s_last  = 1'b0;
         if (closing) break;
      end
   endtask

   task automatic waitIdle();
      int n = 0;
      while (!(s_ready && expBeatQ.size() == 0 && expFrameQ.size() == 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) failBound("drain to idle");
   endtask

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // FFT core stand-in: checks the presented frame, then answers with bins.
   initial begin
      int d;
      logic [XW-1:0] y, yi;
      beat_t b;
      core_resultValid = 1'b0;
      core_y   = '0;
      core_y_i = '0;
      forever begin
         @(negedge clk);
         if (rst_n && core_isValid) begin
            lastStartCyc = cyc;
            if (expFrameQ.size() == 0) begin
               checkOutput("unexpected core start", 1'b1, 1'b0);
            end else begin
               curFrame = expFrameQ.pop_front();
               checkOutput("core_x frame", core_x, curFrame);
               frameActive = 1;
            end
            checkOutput("start latency", XW'(cyc), XW'(closeCyc));
            @(negedge clk);
            checkOutput("core_isValid width", core_isValid, 1'b0);
            if (respondEn) begin
               d = fixedDelay ? 5 : $urandom_range(1, 12);
               repeat (d - 1) @(negedge clk);
               for (int k = 0; k < N; k++) begin
                  y[k*W +: W]  = identityData ? sample_t'(k)  : sample_t'($urandom);
                  yi[k*W +: W] = identityData ? sample_t'(-k) : sample_t'($urandom);
                  b.re   = y[k*W +: W];
                  b.im   = yi[k*W +: W];
                  b.idx  = IW'(k);
                  b.last = (k == N - 1);
                  expBeatQ.push_back(b);
               end
               core_y = y;
               core_y_i = yi;
               core_resultValid = 1'b1;
               @(negedge clk);
               core_resultValid = 1'b0;
               checkOutput("result to m_valid", {m_valid, m_index}, {1'b1, 3'd0});
               if (strayEn) begin
                  for (int k = 0; k < N; k++) begin
                     core_y[k*W +: W]   = sample_t'($urandom);
                     core_y_i[k*W +: W] = sample_t'($urandom);
                  end
                  core_resultValid = 1'b1;
                  @(negedge clk);
                  core_resultValid = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: egress scoreboard, stall hold, frame stability and error pulses.
   initial begin
      bit prevStall = 0, readyAfterLast = 0;
      beat_t held, exp;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prevStall = 0;
            readyAfterLast = 0;
            frameActive = 0;
         end else begin
            if (readyAfterLast) begin
               checkOutput("s_ready after drain", s_ready, 1'b1);
               readyAfterLast = 0;
            end
            if (frameActive) begin
               if (s_ready) frameActive = 0;
               else checkOutput("core_x stable", core_x, curFrame);
            end
            if (prevStall) begin
               checkOutput("stall hold", {m_valid, m_re, m_im, m_index, m_last}, {1'b1, held});
            end
            prevStall = 0;
            if (m_valid) begin
               if (m_ready) begin
                  if (expBeatQ.size() == 0) begin
                     checkOutput("unexpected beat", 1'b1, 1'b0);
                  end else begin
                     exp = expBeatQ.pop_front();
                     checkOutput("egress beat", {m_re, m_im, m_index, m_last}, exp);
                  end
                  if (m_last) begin
                     checkOutput("s_ready during drain", s_ready, 1'b0);
                     readyAfterLast = 1;
                  end
               end else begin
                  prevStall = 1;
                  held = {m_re, m_im, m_index, m_last};
               end
            end
            if (frame_err) begin
               seenFrameErrs++;
               checkOutput("frame_err timing", XW'(cyc), XW'(earlyCyc));
            end
            if (timeout_err) begin
               seenTimeouts++;
               checkOutput("timeout timing", {XW'(cyc), s_ready},
                           {XW'(lastStartCyc + TO + 1), 1'b1});
            end
         end
      end
   end

   initial begin
      int n;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      #3;
      checkOutput("reset s_ready", s_ready, 1'b1);
      checkOutput("reset egress", {m_valid, m_last, m_index, m_re, m_im},
                  {1'b0, 1'b0, 3'd0, 16'd0, 16'd0});
      checkOutput("reset pulses", {core_isValid, frame_err, timeout_err}, 3'b000);
      checkOutput("reset core_x", core_x, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("s_ready after reset", s_ready, 1'b1);

      $display("[TB] ramp frame, identity core, fixed delay");
      fixedDelay = 1;
      identityData = 1;
      applyStimulus(N, 1, 0);
      waitIdle();

      $display("[TB] early s_last on third sample");
      identityData = 0;
      applyStimulus(2, 0, 0);
      waitIdle();

      $display("[TB] randomized frames with egress backpressure");
      fixedDelay = 0;
      strayEn = 1;
      randReady = 1;
      for (int f = 0; f < 14; f++) begin
         applyStimulus($urandom_range(0, 11), 0, 2);
      end
      waitIdle();

      $display("[TB] core timeout");
      strayEn = 0;
      randReady = 0;
      respondEn = 0;
      applyStimulus(N, 0, 0);
      n = 0;
      while (seenTimeouts == 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (seenTimeouts == 0) failBound("timeout pulse");
      respondEn = 1;
      waitIdle();
      applyStimulus(N, 0, 1);
      waitIdle();

      $display("[TB] reset during drain");
      applyStimulus(N, 0, 0);
      n = 0;
      @(negedge clk);
      while (!(m_valid && m_index == 3'd3) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) failBound("fourth drain beat");
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("reset drain egress", {m_valid, m_last, m_index, m_re}, {1'b0, 1'b0, 3'd0, 16'd0});
      checkOutput("reset drain s_ready", s_ready, 1'b1);
      expBeatQ.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(N, 1, 0);
      waitIdle();

      checkOutput("frame_err count", XW'(seenFrameErrs), XW'(expFrameErrs));
      checkOutput("timeout_err count", XW'(seenTimeouts), XW'(1));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
